// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: PLL reset hold, lock wait/filter, staggered domain release, retry on loss.
// Optional lock-loss counter output enabled by defining PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_sequencer #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_FILTER  = 1024,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int NUM_DOMAINS  = 6,
    parameter int STAGGER      = 8,
    parameter int MAX_RETRY    = 7
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   restart_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fail,
    output logic [3:0]             retry_cnt
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]             lock_loss_cnt
`endif
);

    localparam int MAX_AB  = (RST_HOLD > LOCK_FILTER) ? RST_HOLD : LOCK_FILTER;
    localparam int MAX_CD  = (LOCK_TIMEOUT > STAGGER) ? LOCK_TIMEOUT : STAGGER;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx, cnt_inc;
    logic [1:0]             lock_sync;
    logic                   lock_s;
    logic                   pll_rst_nx, ready_nx, fail_nx;
    logic [NUM_DOMAINS-1:0] dom_nx;
    logic [3:0]             retry_nx;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[0], pll_locked};
        end
    end

    assign lock_s  = lock_sync[1];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RESET_PLL;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            fail         <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pll_rst      <= pll_rst_nx;
            domain_rst_n <= dom_nx;
            ready        <= ready_nx;
            fail         <= fail_nx;
            retry_cnt    <= retry_nx;
        end
    end

    // Outputs are computed as next-state values so every output is a flop.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt_inc;
        pll_rst_nx = pll_rst;
        dom_nx     = domain_rst_n;
        ready_nx   = ready;
        fail_nx    = fail;
        retry_nx   = retry_cnt;

        if (restart_req) begin
            state_nx   = S_RESET_PLL;
            cnt_nx     = '0;
            pll_rst_nx = 1'b1;
            dom_nx     = '0;
            ready_nx   = 1'b0;
            fail_nx    = 1'b0;
            retry_nx   = '0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == HOLD_LAST) begin
                        state_nx   = S_WAIT_LOCK;
                        cnt_nx     = '0;
                        pll_rst_nx = 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = S_FILTER;
                        cnt_nx   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_nx   = retry_cnt + 4'd1;
                        cnt_nx     = '0;
                        pll_rst_nx = 1'b1;
                        if (retry_nx == 4'(MAX_RETRY)) begin
                            state_nx = S_FAIL;
                            fail_nx  = 1'b1;
                        end else begin
                            state_nx = S_RESET_PLL;
                        end
                    end
                end
                S_FILTER: begin
                    if (!lock_s) begin
                        state_nx = S_WAIT_LOCK;
                        cnt_nx   = '0;
                    end else if (cnt == FILTER_LAST) begin
                        state_nx = S_RELEASE;
                        cnt_nx   = '0;
                        dom_nx   = NUM_DOMAINS'(1);
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        state_nx   = S_RESET_PLL;
                        cnt_nx     = '0;
                        pll_rst_nx = 1'b1;
                        dom_nx     = '0;
                    end else if (&domain_rst_n) begin
                        state_nx = S_RUN;
                        cnt_nx   = '0;
                        ready_nx = 1'b1;
                        retry_nx = '0;
                    end else if (cnt == STAGGER_LAST) begin
                        // Shifting in ones releases the next-higher domain.
                        cnt_nx = '0;
                        dom_nx = NUM_DOMAINS'({domain_rst_n, 1'b1});
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nx   = S_RESET_PLL;
                        cnt_nx     = '0;
                        pll_rst_nx = 1'b1;
                        dom_nx     = '0;
                        ready_nx   = 1'b0;
                    end
                end
                S_FAIL: begin
                    pll_rst_nx = 1'b1;
                    dom_nx     = '0;
                    fail_nx    = 1'b1;
                end
                default: begin
                    state_nx   = S_RESET_PLL;
                    cnt_nx     = '0;
                    pll_rst_nx = 1'b1;
                    dom_nx     = '0;
                    ready_nx   = 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic lock_lost;

    assign lock_lost = (state == S_RUN) && !lock_s && !restart_req;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios with literal expectations, then random lock/restart
// traffic, all checked every cycle against a phase/elapsed-time model of the sequencing rules.
module tb_pll_lock_sequencer;

    localparam int RST_HOLD     = 4;
    localparam int LOCK_FILTER  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int NUM_DOMAINS  = 3;
    localparam int STAGGER      = 2;
    localparam int MAX_RETRY    = 2;

    logic                   refclk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   pll_locked = 1'b0;
    logic                   restart_req = 1'b0;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   ready;
    logic                   fail;
    logic [3:0]             retry_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0]             lock_loss_cnt;
`endif

    pll_lock_sequencer #(
        .RST_HOLD     (RST_HOLD),
        .LOCK_FILTER  (LOCK_FILTER),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .NUM_DOMAINS  (NUM_DOMAINS),
        .STAGGER      (STAGGER),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .restart_req  (restart_req),
        .pll_rst      (pll_rst),
        .domain_rst_n (domain_rst_n),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt)
`ifdef PLL_LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which phase we are in and how many edges have elapsed in it.
    typedef enum int {M_HOLD, M_WAIT, M_FILT, M_REL, M_RUN, M_FAILED} mphase_t;
    mphase_t    m_phase   = M_HOLD;
    int         m_t       = 0;
    int         m_retries = 0;
    int         m_loss    = 0;
    logic [1:0] m_sync    = 2'b00;
    logic       m_ls;

    function automatic int exp_dom();
        int n;
        if (m_phase == M_RUN) return (1 << NUM_DOMAINS) - 1;
        if (m_phase != M_REL) return 0;
        n = m_t / STAGGER + 1;
        if (n > NUM_DOMAINS) n = NUM_DOMAINS;
        return (1 << n) - 1;
    endfunction

    initial begin
        forever begin
            @(posedge refclk or negedge rst_n);
            if (!rst_n) begin
                m_phase = M_HOLD; m_t = 0; m_retries = 0; m_loss = 0; m_sync = 2'b00;
            end else begin
                m_ls   = m_sync[1];
                m_sync = {m_sync[0], pll_locked};
                if (restart_req) begin
                    m_phase = M_HOLD; m_t = 0; m_retries = 0;
                end else begin
                    case (m_phase)
                        M_HOLD: begin
                            m_t++;
                            if (m_t == RST_HOLD) begin m_phase = M_WAIT; m_t = 0; end
                        end
                        M_WAIT: begin
                            if (m_ls) begin
                                m_phase = M_FILT; m_t = 0;
                            end else begin
                                m_t++;
                                if (m_t == LOCK_TIMEOUT) begin
                                    m_retries++;
                                    m_phase = (m_retries == MAX_RETRY) ? M_FAILED : M_HOLD;
                                    m_t = 0;
                                end
                            end
                        end
                        M_FILT: begin
                            if (!m_ls) begin
                                m_phase = M_WAIT; m_t = 0;
                            end else begin
                                m_t++;
                                if (m_t == LOCK_FILTER) begin m_phase = M_REL; m_t = 0; end
                            end
                        end
                        M_REL: begin
                            if (!m_ls) begin
                                m_phase = M_HOLD; m_t = 0;
                            end else begin
                                m_t++;
                                if (m_t == (NUM_DOMAINS - 1) * STAGGER + 1) begin
                                    m_phase = M_RUN; m_t = 0; m_retries = 0;
                                end
                            end
                        end
                        M_RUN: begin
                            if (!m_ls) begin
                                m_phase = M_HOLD; m_t = 0;
                                if (m_loss < 255) m_loss++;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge refclk);
            check("pll_rst", pll_rst, (m_phase == M_HOLD || m_phase == M_FAILED) ? 1 : 0);
            check("domain_rst_n", domain_rst_n, exp_dom());
            check("ready", ready, (m_phase == M_RUN) ? 1 : 0);
            check("fail", fail, (m_phase == M_FAILED) ? 1 : 0);
            check("retry_cnt", retry_cnt, m_retries);
`ifdef PLL_LOCK_LOSS_COUNT_EN
            check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    int run_left;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_pll_rst", pll_rst, 1);
        check("rst_dom", domain_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_cnt, 0);
        rst_n = 1'b1;

        // 1: clean bring-up
        for (int i = 1; i <= 22; i++) begin
            tick();
            case (i)
                3:  check("t1_pll_rst_hi", pll_rst, 1);
                4:  check("t1_pll_rst_lo", pll_rst, 0);
                15: check("t1_dom_000", domain_rst_n, 0);
                16: check("t1_dom_001", domain_rst_n, 1);
                17: check("t1_dom_001b", domain_rst_n, 1);
                18: check("t1_dom_011", domain_rst_n, 3);
                20: begin
                    check("t1_dom_111", domain_rst_n, 7);
                    check("t1_ready_lo", ready, 0);
                end
                21: begin
                    check("t1_ready_hi", ready, 1);
                    check("t1_retry", retry_cnt, 0);
                end
                default: ;
            endcase
            if (i == 5) pll_locked = 1'b1;
        end

        // 2: one-cycle lock glitch while filtering
        restart_req = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            tick();
            case (i)
                1:  begin check("t2_pll_rst", pll_rst, 1); restart_req = 1'b0; end
                10: pll_locked = 1'b0;
                11: pll_locked = 1'b1;
                12: check("t2_dom_12", domain_rst_n, 0);
                13: begin
                    check("t2_dom_13", domain_rst_n, 0);
                    check("t2_retry", retry_cnt, 0);
                end
                22: check("t2_dom_001", domain_rst_n, 1);
                26: check("t2_ready_lo", ready, 0);
                27: check("t2_ready_hi", ready, 1);
                default: ;
            endcase
        end

        // 3: timeouts to FAIL, then restart; 5: restart coinciding with a timeout
        pll_locked  = 1'b0;
        restart_req = 1'b1;
        for (int i = 1; i <= 117; i++) begin
            tick();
            case (i)
                1:  restart_req = 1'b0;
                36: check("t3_retry0", retry_cnt, 0);
                37: begin
                    check("t3_retry1", retry_cnt, 1);
                    check("t3_pll_rst1", pll_rst, 1);
                end
                72: check("t3_fail_lo", fail, 0);
                73: begin
                    check("t3_fail_hi", fail, 1);
                    check("t3_retry2", retry_cnt, 2);
                    check("t3_pll_rst_fail", pll_rst, 1);
                end
                80: begin
                    check("t3_fail_held", fail, 1);
                    restart_req = 1'b1;
                end
                81: begin
                    restart_req = 1'b0;
                    check("t3_restart_fail", fail, 0);
                    check("t3_restart_retry", retry_cnt, 0);
                    check("t3_restart_pll_rst", pll_rst, 1);
                end
                84: check("t3_hold_end", pll_rst, 1);
                85: check("t3_hold_done", pll_rst, 0);
                116: restart_req = 1'b1;
                117: begin
                    restart_req = 1'b0;
                    check("t5_retry", retry_cnt, 0);
                    check("t5_fail", fail, 0);
                    check("t5_pll_rst", pll_rst, 1);
                end
                default: ;
            endcase
        end

        // 4: loss of lock in RUN
        pll_locked = 1'b1;
        for (int k = 0; k < 200 && !ready; k++) tick();
        check("t4_reach_ready", ready, 1);
        pll_locked = 1'b0;
        tick();
        check("t4_ready_l1", ready, 1);
        tick();
        check("t4_ready_l2", ready, 1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("t4_loss0", lock_loss_cnt, 0);
`endif
        tick();
        check("t4_ready_l3", ready, 0);
        check("t4_dom_l3", domain_rst_n, 0);
        check("t4_pll_rst_l3", pll_rst, 1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("t4_loss1", lock_loss_cnt, 1);
`endif

        // 6: asynchronous reset in the middle of the release sequence
        pll_locked = 1'b1;
        for (int k = 0; k < 200 && domain_rst_n != 3'b011; k++) tick();
        check("t6_reach_011", domain_rst_n, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_dom", domain_rst_n, 0);
        check("t6_async_pll_rst", pll_rst, 1);
        check("t6_async_ready", ready, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Random lock behaviour with occasional restarts and resets
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            restart_req = ($urandom_range(0, 149) == 0);
            if (run_left == 0) begin
                pll_locked = ~pll_locked;
                run_left = pll_locked ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 80));
            end else begin
                run_left--;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
        end
        restart_req = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
